// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RISC-V fetch definitions: word geometry, memory fill word and the queue entry type.
package instruction_fetch_unit_pkg;
  localparam int          XLEN        = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] IMEM_FILL   = 32'h0000_000D;
  localparam logic [31:0] NOP_ADDI    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular buffer of {pc, instr} with wrap-bit pointers and a synchronous flush.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: drives instruction memory, queues {pc, instr} for decode, handles redirects and faults.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);
  localparam logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(IMEM_WORDS * INSTR_BYTES);

  logic [31:0]  fetch_pc;
  logic         bad_pc;
  logic         push;
  logic         pop;
  logic         q_empty;
  logic         q_full;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Widened compare so the memory-size bound cannot wrap.
  assign bad_pc = (fetch_pc[1:0] != 2'b00) || ({1'b0, fetch_pc} >= IMEM_BYTES);
  assign pop    = id_valid && id_ready;
  assign push   = !redirect_valid && !fetch_fault && !bad_pc && (!q_full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      fetch_fault <= 1'b0;
    end else begin
      if (push)   fetch_pc    <= next_pc(fetch_pc);
      if (bad_pc) fetch_fault <= 1'b1;
    end
  end

  assign wr_entry = '{pc: fetch_pc, instr: imem_instr};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .empty   (q_empty),
    .full    (q_full)
  );

  assign imem_pc  = fetch_pc;
  assign id_valid = !q_empty;
  assign id_pc    = head.pc;
  assign id_instr = head.instr;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: queue-level reference model plus directed scenarios and randomized traffic.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          IMEM_WORDS = 128;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_fault;

  logic [31:0] mem [IMEM_WORDS];

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic        mfault;

  always #5 clk = ~clk;

  assign imem_instr = (imem_pc < IMEM_BYTES) ? mem[imem_pc[8:2]] : IMEM_FILL;

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mword(input logic [31:0] pc);
    return (pc < IMEM_BYTES) ? mem[pc[8:2]] : IMEM_FILL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc    = RESET_PC;
    mfault = 1'b0;
  endtask

  // One clock edge of the fetch unit, described as queue operations.
  task automatic model_step();
    int          sz;
    bit          pop;
    bit          bad;
    sz  = mq.size();
    pop = (sz != 0) && id_ready;
    if (redirect_valid) begin
      mq.delete();
      mpc    = redirect_pc;
      mfault = 1'b0;
    end else begin
      bad = (mpc[1:0] != 2'b00) || (mpc >= IMEM_BYTES);
      if (pop) void'(mq.pop_front());
      if (!mfault && !bad && (sz < DEPTH || pop)) begin
        mq.push_back({mpc, mword(mpc)});
        mpc = mpc + 32'd4;
      end
      if (bad) mfault = 1'b1;
    end
  endtask

  task automatic compare();
    logic [63:0] h;
    chk("id_valid", {31'b0, id_valid}, {31'b0, mq.size() != 0});
    chk("imem_pc", imem_pc, mpc);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, mfault});
    if (mq.size() != 0) begin
      h = mq[0];
      chk("id_pc", id_pc, h[63:32]);
      chk("id_instr", id_instr, h[31:0]);
    end
  endtask

  // Inputs are set at the falling edge; the model advances on the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input int offset);
    #(offset);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_imem_pc", imem_pc, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = (i << 20) | ($urandom & 32'hF_FFFF);
    mem[IMEM_WORDS-1] = NOP_ADDI;
    model_reset();
    @(negedge clk);
    do_reset(0);

    // Streaming from reset at one instruction per cycle.
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_valid", {31'b0, id_valid}, 32'h1);
      chk("t1_pc", id_pc, 32'(k * 4));
      chk("t1_instr", id_instr, mem[k]);
    end

    // Back-pressure fills the queue and freezes the fetch PC.
    do_reset(0);
    id_ready = 1'b0;
    repeat (5) cycle();
    chk("t2_imem_pc", imem_pc, 32'h8);
    chk("t2_head", id_pc, 32'h0);
    id_ready = 1'b1;
    cycle();
    chk("t2_pc4", id_pc, 32'h4);
    cycle();
    chk("t2_pc8", id_pc, 32'h8);

    // Redirect while two entries are queued.
    redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
    cycle();
    chk("t3_flushed", {31'b0, id_valid}, 32'h0);
    redirect_valid = 1'b0; id_ready = 1'b1;
    cycle();
    chk("t3_pc40", id_pc, 32'h40);
    cycle();
    chk("t3_pc44", id_pc, 32'h44);

    // Misaligned redirect faults; a good redirect recovers.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("t4_fault", {31'b0, fetch_fault}, 32'h1);
    repeat (3) cycle();
    chk("t4_novalid", {31'b0, id_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cycle();
    chk("t4_clear", {31'b0, fetch_fault}, 32'h0);
    redirect_valid = 1'b0;
    cycle();
    chk("t4_pc10", id_pc, 32'h10);

    // Run off the end of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'h1F0;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t5_pc", id_pc, 32'h1F0 + 32'(k * 4));
    end
    chk("t5_last_instr", id_instr, NOP_ADDI);
    repeat (4) cycle();
    chk("t5_imem_pc", imem_pc, 32'h200);
    chk("t5_fault", {31'b0, fetch_fault}, 32'h1);
    chk("t5_drained", {31'b0, id_valid}, 32'h0);

    // Asynchronous reset with a full queue.
    redirect_valid = 1'b1; redirect_pc = 32'h20; id_ready = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    do_reset(2);
    id_ready = 1'b1;
    cycle();
    chk("t6_restart", id_pc, RESET_PC);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 99);
      if (r < 70)      redirect_pc = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
      else if (r < 80) redirect_pc = 32'h1E0 + (32'($urandom_range(0, 7)) << 2);
      else if (r < 90) redirect_pc = (32'($urandom_range(0, IMEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      else             redirect_pc = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 4));
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
